button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Conditions one raw push-button input for the counter/display path.
//   Synchronises, debounces, and produces a clean level plus single-cycle
//   press/release strobes. Adds long-press detection and auto-repeat.
//   Sits directly upstream of the digit counter feeding binary_to_7seg, and
//   is a drop-in superset of debounce_switch.
// PARAMETERS
//   DEBOUNCE_LIMIT  250000    cycles raw input must be stable to change o_Switch (10 ms @ 25 MHz); >= 2
//   LONG_LIMIT      25000000  cycles o_Switch held high before o_LongPress (1 s); >= 2
//   REPEAT_LIMIT    5000000   cycles between o_Repeat strobes while held (200 ms); >= 2
// PORTS
//   CLK         in   1  system clock; all logic on posedge
//   RST         in   1  synchronous reset, active-high
//   Switch      in   1  raw button, asynchronous, 1 = pressed
//   o_Switch    out  1  debounced level, 1 = pressed
//   o_Press     out  1  one-cycle strobe on debounced 0->1
//   o_Release   out  1  one-cycle strobe on debounced 1->0
//   o_LongPress out  1  one-cycle strobe when the hold reaches LONG_LIMIT
//   o_Held      out  1  level: long press in progress (state HELD)
//   o_Repeat    out  1  one-cycle strobe every REPEAT_LIMIT cycles while HELD
// BEHAVIOUR
//   Reset:
//     - Clock: one clock, CLK. Reset: RST is synchronous and active-high.
//     - RST=1 clears all outputs, both sync flops, and all counters to 0.
//     - The FSM goes to IDLE.
//     - Reset has priority over every other event.
//     - Reset mid-press forces o_Switch=0 with no o_Release. If the button is
//       still down after reset, a fresh o_Press follows the full debounce.
//   Synchroniser:
//     - Two flops: sync1 <= Switch; sync2 <= sync1.
//     - Only sync2 is used downstream.
//   Debounce:
//     - Counter width $clog2(DEBOUNCE_LIMIT).
//     - sync2 == o_Switch: clear the counter.
//     - Otherwise, at count DEBOUNCE_LIMIT-1: toggle o_Switch and clear.
//     - Otherwise: increment.
//     - Any glitch shorter than DEBOUNCE_LIMIT cycles restarts the count and
//       never reaches o_Switch.
//     - Latency: a clean raw edge appears on o_Switch DEBOUNCE_LIMIT+2 edges later.
//   Strobes:
//     - o_Press/o_Release are registered and are high in the first cycle
//       o_Switch shows its new value.
//     - o_Press/o_Release are never high together.
//   FSM, states IDLE, PRESSED, HELD:
//     - IDLE:
//       - debounced rise: pulse o_Press, go to PRESSED, clear hold_cnt.
//     - PRESSED:
//       - hold_cnt increments each cycle o_Switch=1.
//       - At LONG_LIMIT-1: pulse o_LongPress, go to HELD, set o_Held=1,
//         clear rep_cnt.
//       - o_LongPress is high exactly LONG_LIMIT cycles after the o_Press cycle.
//     - HELD:
//       - rep_cnt increments.
//       - At REPEAT_LIMIT-1: pulse o_Repeat, clear rep_cnt.
//       - First o_Repeat comes REPEAT_LIMIT cycles after o_LongPress.
//     - Any state with a debounced fall: pulse o_Release, go to IDLE,
//       o_Held=0, clear hold_cnt and rep_cnt.
//     - The fall takes priority over a coincident o_LongPress/o_Repeat
//       terminal count; that strobe is suppressed.
//   Widths:
//     - hold_cnt is $clog2(LONG_LIMIT) bits; rep_cnt is $clog2(REPEAT_LIMIT) bits.
//     - Counters saturate by state change, never wrap.
// TESTING  (DEBOUNCE_LIMIT=4, LONG_LIMIT=20, REPEAT_LIMIT=8)
//   1. Reset, Switch=0 for 10 cycles -> all outputs 0.
//   2. Switch 0->1 held -> o_Switch=1 and o_Press=1 exactly 6 edges later,
//      o_Press for 1 cycle only.
//   3. Switch pulses high for 3 cycles, repeated with gaps of 3 -> o_Switch
//      stays 0, no strobes.
//   4. Press held 60 cycles -> o_LongPress 20 cycles after o_Press, o_Held=1,
//      then o_Repeat at +8, +16, +24, ...
//   5. Release during HELD -> o_Release 1 cycle, 6 edges after the raw fall.
//      o_Held=0 in the same cycle, no further o_Repeat.
//   6. RST pulsed while held in HELD -> outputs 0 next cycle, no o_Release.
//      Switch still 1 -> new o_Press 6 edges after RST deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce, press/release strobes,
// long-press detection and auto-repeat while the button stays held.
module button_conditioner #(
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int LONG_LIMIT     = 25000000,
   parameter int REPEAT_LIMIT   = 5000000
) (
   input  logic CLK,
   input  logic RST,
   input  logic Switch,
   output logic o_Switch,
   output logic o_Press,
   output logic o_Release,
   output logic o_LongPress,
   output logic o_Held,
   output logic o_Repeat
);

   localparam int DB_W   = $clog2(DEBOUNCE_LIMIT);
   localparam int HOLD_W = $clog2(LONG_LIMIT);
   localparam int REP_W  = $clog2(REPEAT_LIMIT);

   localparam logic [DB_W-1:0]   DB_TC   = DB_W'(DEBOUNCE_LIMIT - 1);
   localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(LONG_LIMIT - 1);
   localparam logic [REP_W-1:0]  REP_TC  = REP_W'(REPEAT_LIMIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   logic              r_sync1, r_sync2;
   logic [DB_W-1:0]   r_db_cnt;
   logic              r_switch;
   logic              r_press, r_release, r_long, r_repeat;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [REP_W-1:0]  r_rep_cnt;
   state_t            r_state;

   logic              w_toggle, w_rise, w_fall;
   logic [DB_W-1:0]   w_db_cnt_nxt;
   logic [HOLD_W-1:0] w_hold_cnt_nxt;
   logic [REP_W-1:0]  w_rep_cnt_nxt;
   logic              w_long_nxt, w_repeat_nxt;
   state_t            w_state_nxt;

   // NOTE: every signal gets a default before any branch so no path can infer a latch.
   always_comb begin
      w_toggle     = (r_sync2 != r_switch) && (r_db_cnt == DB_TC);
      w_rise       = w_toggle && !r_switch;
      w_fall       = w_toggle &&  r_switch;
      w_db_cnt_nxt = (r_sync2 == r_switch || w_toggle) ? '0 : r_db_cnt + 1'b1;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      w_rep_cnt_nxt  = r_rep_cnt;
      w_long_nxt     = 1'b0;
      w_repeat_nxt   = 1'b0;
      // A debounced fall wins over any terminal count landing in the same cycle.
      if (w_fall) begin
         w_state_nxt    = ST_IDLE;
         w_hold_cnt_nxt = '0;
         w_rep_cnt_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  w_state_nxt    = ST_PRESSED;
                  w_hold_cnt_nxt = '0;
               end
            end
            ST_PRESSED: begin
               if (r_hold_cnt == HOLD_TC) begin
                  w_state_nxt   = ST_HELD;
                  w_long_nxt    = 1'b1;
                  w_rep_cnt_nxt = '0;
               end else begin
                  w_hold_cnt_nxt = r_hold_cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (r_rep_cnt == REP_TC) begin
                  w_repeat_nxt  = 1'b1;
                  w_rep_cnt_nxt = '0;
               end else begin
                  w_rep_cnt_nxt = r_rep_cnt + 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_db_cnt   <= '0;
         r_switch   <= 1'b0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_long     <= 1'b0;
         r_repeat   <= 1'b0;
         r_hold_cnt <= '0;
         r_rep_cnt  <= '0;
         r_state    <= ST_IDLE;
      end else begin
         r_sync1    <= Switch;
         r_sync2    <= r_sync1;
         r_db_cnt   <= w_db_cnt_nxt;
         r_switch   <= r_switch ^ w_toggle;
         r_press    <= w_rise;
         r_release  <= w_fall;
         r_long     <= w_long_nxt;
         r_repeat   <= w_repeat_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_rep_cnt  <= w_rep_cnt_nxt;
         r_state    <= w_state_nxt;
      end
   end

   assign o_Switch    = r_switch;
   assign o_Press     = r_press;
   assign o_Release   = r_release;
   assign o_LongPress = r_long;
   assign o_Held      = (r_state == ST_HELD);
   assign o_Repeat    = r_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios then random button activity,
// all outputs compared every cycle against an event/age-based reference model.
module tb_button_conditioner;

   localparam int DL = 4;
   localparam int LL = 20;
   localparam int RL = 8;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic Switch = 1'b0;
   logic o_Switch, o_Press, o_Release, o_LongPress, o_Held, o_Repeat;

   int checks = 0;
   int errors = 0;

   button_conditioner #(
      .DEBOUNCE_LIMIT (DL),
      .LONG_LIMIT     (LL),
      .REPEAT_LIMIT   (RL)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .Switch      (Switch),
      .o_Switch    (o_Switch),
      .o_Press     (o_Press),
      .o_Release   (o_Release),
      .o_LongPress (o_LongPress),
      .o_Held      (o_Held),
      .o_Repeat    (o_Repeat)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b (Switch,Press,Release,Long,Held,Repeat)", tag, got, exp);
      end
   endtask

   // Reference model: synchronised samples since the last level change, and the
   // age (in edges) of the current debounced press.
   int   edge_n = 0;
   logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0;
   logic hist[$];
   int   press_edge = -1;
   logic [5:0] exp_v = '0;
   int   n_long_m = 0, n_rep_m = 0, n_long_d = 0, n_rep_d = 0;

   task automatic model_edge(input logic rst_v, input logic sw_v);
      logic s2_pre, tog, press, rel, lng, held, rpt;
      int age;
      edge_n++;
      if (rst_v) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
         hist.delete();
         press_edge = -1;
         exp_v = '0;
         return;
      end
      s2_pre = m_s2;
      m_s2 = m_s1;
      m_s1 = sw_v;
      hist.push_back(s2_pre);
      if (hist.size() > DL) void'(hist.pop_front());
      tog = (hist.size() == DL);
      foreach (hist[i]) if (hist[i] == m_level) tog = 1'b0;
      press = 1'b0; rel = 1'b0;
      if (tog) begin
         m_level = !m_level;
         hist.delete();
         if (m_level) begin press = 1'b1; press_edge = edge_n; end
         else begin rel = 1'b1; press_edge = -1; end
      end
      age  = m_level ? edge_n - press_edge : -1;
      lng  = m_level && (age == LL);
      held = m_level && (age >= LL);
      rpt  = m_level && (age > LL) && ((age - LL) % RL == 0);
      if (lng) n_long_m++;
      if (rpt) n_rep_m++;
      exp_v = {m_level, press, rel, lng, held, rpt};
   endtask

   task automatic step(input logic rst_v, input logic sw_v);
      @(negedge CLK);
      RST = rst_v;
      Switch = sw_v;
      @(posedge CLK);
      model_edge(rst_v, sw_v);
      #1;
      if (o_LongPress) n_long_d++;
      if (o_Repeat) n_rep_d++;
      check($sformatf("cyc%0d", edge_n),
            {o_Switch, o_Press, o_Release, o_LongPress, o_Held, o_Repeat}, exp_v);
   endtask

   task automatic hold(input logic rst_v, input logic sw_v, input int n);
      for (int i = 0; i < n; i++) step(rst_v, sw_v);
   endtask

   initial begin
      // Reset, then idle with the button up.
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 10);
      // Long hold: press, long-press, several repeats, then release.
      hold(1'b0, 1'b1, 60);
      hold(1'b0, 1'b0, 12);
      // Glitches shorter than the debounce window.
      for (int k = 0; k < 5; k++) begin
         hold(1'b0, 1'b1, 3);
         hold(1'b0, 1'b0, 3);
      end
      hold(1'b0, 1'b0, 6);
      // Reset while in the held state with the button still down.
      hold(1'b0, 1'b1, 40);
      step(1'b1, 1'b1);
      hold(1'b0, 1'b1, 15);
      hold(1'b0, 1'b0, 10);
      // Random activity: glitches, short presses, long holds, occasional resets.
      for (int seg = 0; seg < 150; seg++) begin
         int kind;
         int len;
         logic lvl;
         kind = $urandom_range(0, 9);
         lvl  = 1'($urandom_range(0, 1));
         if (kind == 0) step(1'b1, lvl);
         else begin
            len = (kind < 4) ? $urandom_range(1, DL + 1) : $urandom_range(DL + 2, LL + 4 * RL);
            hold(1'b0, lvl, len);
         end
      end
      hold(1'b0, 1'b0, 10);
      check("long_count", 6'(n_long_d), 6'(n_long_m));
      check("repeat_count", 6'(n_rep_d), 6'(n_rep_m));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
